count_display_mux: RTL
======================

Name: count_display_mux

Overview:
- Downstream consumer of the 4-bit up/down counter. Shows the counter value and the count direction on the board's 4-digit common-anode seven-segment display.
- Digits 1:0 show the count as decimal "0".."15", with the leading zero optionally blanked.
- Digit 2 is blank. Digit 3 shows 'U' when counting up and 'd' when counting down.
- A prescaled time-multiplexed scan drives the display. Inputs are snapshotted once per frame, so a frame never mixes two count values.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot; legal range 2..2^24-1. The default gives 1 kHz per digit at 100 MHz.
- DEAD_CYCLES, 1000: cycles at the start of each slot with all anodes off, for anti-ghosting. Legal range 0..REFRESH_DIV-1.
- BLANK_LEADING, 1: 1 blanks the tens digit when the value is below 10; 0 shows "0".

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high. Clock is clk.
- count, input, 4: counter value, 0..15.
- up, input, 1: direction from the counter; 1 means up, 0 means down.
- an, output, 4: digit anodes, active-low; an[0] is the rightmost digit.
- seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- dp, output, 1: decimal point, active-low. Held at 1 (off).

Behaviour:
- Reset, asynchronous:
  - pre = 0, idx = 0.
  - snap_count = 0, snap_up = 0.
  - an = 4'b1111, seg = 7'b1111111, dp = 1.
- Prescaler `pre`:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (pre == REFRESH_DIV-1).
- Digit index `idx` (2 bits):
  - On tick it advances 0→1→2→3→0; otherwise it holds.
  - This forms the 4-state scan FSM, one state per digit (D0, D1, D2, D3).
- Snapshot:
  - On the clock where tick is high and idx == 3, capture snap_count <= count and snap_up <= up. The new frame starts from D0 with the new values.
  - Input changes mid-frame are ignored until the next frame boundary.
  - count and up are synchronous to clk; no synchroniser is needed.
- Decode (combinational, from idx, pre, snap_*):
  - tens = (snap_count >= 10) ? 1 : 0.
  - ones = snap_count - 10*tens, using 4-bit arithmetic; no other width effects.
  - D0 shows ones.
  - D1 shows tens. It is blank if tens == 0 and BLANK_LEADING == 1.
  - D2 is blank.
  - D3 shows 'U' (7'b1000001) if snap_up, else 'd' (7'b0100001).
  - Digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Blank = 1111111.
  - Anode: an_next = ~(4'b0001 << idx). Force an_next = 4'b1111 while pre < DEAD_CYCLES.
- Outputs:
  - an, seg and dp are registered, one clk after decode.
  - Latency: the an/seg change appears on the edge after idx changes, and after the dead window ends.
  - Exactly one anode is low outside dead windows; none is low during them.
- Boundary conditions:
  - count 9→10 mid-frame: the display does not change until the next frame.
  - count 15→0 or 0→15 wrap: shown literally as 15 or 0, with no special case.
  - up toggling with an unchanged count: only D3 changes, at the next frame.
  - Reset mid-slot: outputs blank immediately (asynchronously). The scan restarts at D0 with pre = 0; the first snapshot is taken at the end of the first frame, so the display shows 0/'d' until then.
  - DEAD_CYCLES = 0: no blanking window.

Decomposition:
- Shared package `display_pkg`:
  - SEG_BLANK, SEG_U, SEG_D constants.
  - Digit-code function (0..9 → 7-bit code).
  - Anode-off constant.
- One sub-module, `seg7_decoder`: 4-bit digit plus blank flag in, 7-bit active-low seg out. Purely combinational.
- The prescaler, scan FSM, snapshot and output registers stay in count_display_mux.

Test Plan:
- Bench parameters for all scenarios: REFRESH_DIV=4, DEAD_CYCLES=1.
- Reset held, then released; count=0, up=0 → an=1111, seg=1111111, dp=1 during reset. The first frame scans D0 an=1110 seg=1000000, D1 and D2 blank, D3 seg=0100001.
- count=13, up=1 before the frame boundary → next frame:
  - D0 an=1110 seg=0110000
  - D1 an=1101 seg=1111001
  - D2 an=1011 seg=1111111
  - D3 an=0111 seg=1000001
- count=7 with BLANK_LEADING=1, then with BLANK_LEADING=0 → D1 seg=1111111 for the first, seg=1000000 for the second. D0 seg=1111000 in both.
- Change count 9→10 while idx=1 → the rest of the current frame still shows 9. The next frame shows D1=1111001, D0=1000000.
- Dead window: in every slot, an=1111 for exactly 1 cycle after the idx change, then one low anode for 3 cycles. Never more than one anode low at once.
- Assert reset for 2 cycles while idx=2 → an=1111 and seg=1111111 asynchronously. After release the scan restarts at D0 with the 0/'d' display, and the next snapshot is taken after 16 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and digit-code table for the seven-segment display path.
package display_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned AN_W    = 4;
    localparam int unsigned DIGIT_W = 4;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_U     = 7'b1000001;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;

    // All anodes off (active-low)
    localparam logic [AN_W-1:0]  AN_OFF    = 4'b1111;

    // Decimal digit to active-low segment code; non-decimal values are blank
    function automatic logic [SEG_W-1:0] digit_code(input logic [DIGIT_W-1:0] digit);
        logic [SEG_W-1:0] code;
        case (digit)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational digit-to-segment decoder with a blank override.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    input  logic               i_blank,
    output logic [SEG_W-1:0]   o_seg_c
);

    // Blank wins over the digit value
    always_comb begin
        o_seg_c = SEG_BLANK;
        if (!i_blank) begin
            o_seg_c = digit_code(i_digit);
        end
    end

endmodule

// File: rtl/count_display_mux.sv
// Shows a 4-bit count (as "0".."15") and its direction on a 4-digit
// common-anode display, scanning one digit per prescaler period.
module count_display_mux
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter int unsigned DEAD_CYCLES   = 1000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] count,
    input  logic               up,
    output logic [AN_W-1:0]    an,
    output logic [SEG_W-1:0]   seg,
    output logic               dp
);

    localparam int unsigned      PRE_W    = 24;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_DEAD = PRE_W'(DEAD_CYCLES);

    // Scan states, one per digit position
    localparam logic [1:0] S_D0 = 2'd0;
    localparam logic [1:0] S_D1 = 2'd1;
    localparam logic [1:0] S_D2 = 2'd2;
    localparam logic [1:0] S_D3 = 2'd3;

    logic [PRE_W-1:0]   r_pre;
    logic [1:0]         r_idx;
    logic [1:0]         w_idx_next;
    logic               w_tick;
    logic [DIGIT_W-1:0] r_snap_count;
    logic               r_snap_up;

    logic               w_tens;
    logic [DIGIT_W-1:0] w_ones;
    logic [DIGIT_W-1:0] w_dig_val;
    logic               w_dig_blank;
    logic               w_use_lit;
    logic [SEG_W-1:0]   w_lit;
    logic [SEG_W-1:0]   w_dec_seg;
    logic [SEG_W-1:0]   w_seg_next;
    logic [AN_W-1:0]    w_an_next;

    assign w_tick = (r_pre == PRE_MAX);

    // Prescaler: one digit slot every REFRESH_DIV cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    // Scan FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= S_D0;
        end else begin
            r_idx <= w_idx_next;
        end
    end

    // Scan FSM next state: step to the next digit on each tick
    always_comb begin
        w_idx_next = r_idx;
        if (w_tick) begin
            case (r_idx)
                S_D0:    w_idx_next = S_D1;
                S_D1:    w_idx_next = S_D2;
                S_D2:    w_idx_next = S_D3;
                default: w_idx_next = S_D0;
            endcase
        end
    end

    // Frame-boundary snapshot so one frame never mixes two count values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap_count <= '0;
            r_snap_up    <= 1'b0;
        end else if (w_tick && (r_idx == S_D3)) begin
            r_snap_count <= count;
            r_snap_up    <= up;
        end
    end

    assign w_tens = (r_snap_count >= DIGIT_W'(10));
    assign w_ones = r_snap_count - (w_tens ? DIGIT_W'(10) : DIGIT_W'(0));

    // Pick what the current digit position shows
    always_comb begin
        w_dig_val   = w_ones;
        w_dig_blank = 1'b0;
        w_use_lit   = 1'b0;
        w_lit       = SEG_BLANK;
        case (r_idx)
            S_D0: w_dig_val = w_ones;
            S_D1: begin
                w_dig_val   = {3'b000, w_tens};
                w_dig_blank = !w_tens && BLANK_LEADING;
            end
            S_D2: w_dig_blank = 1'b1;
            default: begin
                w_use_lit = 1'b1;
                w_lit     = r_snap_up ? SEG_U : SEG_D;
            end
        endcase
    end

    seg7_decoder u_dec (
        .i_digit (w_dig_val),
        .i_blank (w_dig_blank),
        .o_seg_c (w_dec_seg)
    );

    // Segment select and anode drive with the anti-ghosting dead window
    always_comb begin
        w_seg_next = w_use_lit ? w_lit : w_dec_seg;
        w_an_next  = ~(AN_W'(1) << r_idx);
        if (r_pre < PRE_DEAD) begin
            w_an_next = AN_OFF;
        end
    end

    // Registered display outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= w_an_next;
            seg <= w_seg_next;
            dp  <= 1'b1;
        end
    end

endmodule
